alu_sub_serial: RTL and testbench
=================================

ALU_SUB_SERIAL -- requirements
Module: alu_sub_serial

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL set the operand and result width in bits.
REQ-002 Parameter BLOCK_WIDTH, default 4, SHALL set the bits processed per cycle; WORD_WIDTH SHALL be an integer multiple of BLOCK_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a subtraction of the a and b values present in the same cycle.
REQ-006 a  input  WORD_WIDTH  SHALL be the minuend.
REQ-007 b  input  WORD_WIDTH  SHALL be the subtrahend.
REQ-008 busy  output  1  SHALL be high while a subtraction is in progress.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking diff and borrow as valid.
REQ-010 diff  output  WORD_WIDTH  SHALL be the registered difference.
REQ-011 borrow  output  1  SHALL be the registered borrow out of the most significant block.

Function
REQ-012 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 SHALL capture a and b, clear the block index and internal borrow, and enter RUN.
REQ-014 RUN SHALL process one BLOCK_WIDTH slice per cycle, LSB slice first, propagating the borrow between slices.
REQ-015 After slice N-1 (N = WORD_WIDTH/BLOCK_WIDTH), the FSM SHALL enter DONE and load diff and borrow.
REQ-016 Timing SHALL be: start sampled in cycle 0, busy=1 in cycles 1..N, done=1 and busy=0 in cycle N+1; for the defaults, done SHALL occur in cycle 9.
REQ-017 In binary mode, diff SHALL equal (a - b) mod 2^WORD_WIDTH, and borrow SHALL be 1 iff a < b unsigned.
REQ-018 In DONE, start=1 SHALL be accepted exactly as in IDLE (back-to-back operation); otherwise DONE SHALL return to IDLE.
REQ-019 start asserted in RUN SHALL be ignored, and the captured operands SHALL NOT change.
REQ-020 diff and borrow SHALL hold their values from DONE until the next DONE; they SHALL NOT show partial results.
REQ-021 a and b SHALL be sampled only in the start-accept cycle; later changes SHALL have no effect on the result.

Reset
REQ-022 When rst is asserted, the block SHALL immediately enter IDLE with busy=0, done=0, diff=0, borrow=0, the block index cleared and the internal borrow cleared.
REQ-023 Reset asserted during RUN SHALL abort the operation with no done pulse; after rst deasserts, the first accepted start SHALL be processed normally.

Configuration
REQ-024 When macro ALU_SUB_BCD_EN is defined, each 4-bit slice SHALL be a BCD digit.
  - raw value a_d - b_d - bin; if negative, add 10 and set the borrow to the next digit.
  - In this mode BLOCK_WIDTH SHALL be 4.
REQ-025 With ALU_SUB_BCD_EN defined, borrow SHALL be 1 iff the decimal value of a is less than that of b.
  - Non-BCD input digits SHALL produce the low 4 bits of the same correction rule.
REQ-026 Without ALU_SUB_BCD_EN, the BCD logic SHALL be absent, and plain binary behaviour per REQ-017 SHALL apply.

Structure
REQ-027 A shared ALU package SHALL hold the FSM state enumeration (IDLE/RUN/DONE) and the default WORD_WIDTH/BLOCK_WIDTH constants, shared with the adder.
REQ-028 A single combinational sub-module, alu_sub_slice, SHALL perform one BLOCK_WIDTH-wide subtraction.
  - inputs: a slice, b slice, borrow in
  - outputs: diff slice, borrow out
  - includes the BCD correction under the macro
  - instantiated once in the top module

Verification
REQ-029 a=0x00000005, b=0x00000003, start pulse -> busy cycles 1-8; done in cycle 9 with diff=0x00000002, borrow=0.
REQ-030 a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1 (full-width borrow ripple).
REQ-031 Back-to-back operations and ignored start in RUN.
  - Start held high through RUN with a changing each cycle -> result uses the first-captured operands only.
  - start in the DONE cycle with a=0x10, b=0x10 -> next done 9 cycles later, diff=0, borrow=0.
REQ-032 rst asserted in cycle 4 of RUN -> busy=0 immediately, no done pulse, diff=0; a subsequent start with a=7, b=2 -> diff=5.
REQ-033 With ALU_SUB_BCD_EN defined:
  - a=0x00000042, b=0x00000017 -> diff=0x00000025, borrow=0.
  - a=0x00000000, b=0x00000001 -> diff=0x99999999, borrow=1.

Source files
------------

// File: rtl/alu_sub_serial_pkg.sv
// Shared state encoding and default sizing for the serial subtractor and its slice.
// Build option ALU_SUB_BCD_EN turns every 4-bit slice into a BCD digit subtractor.
package alu_sub_serial_pkg;

    localparam int DEFAULT_WORD_WIDTH  = 32;
    localparam int DEFAULT_BLOCK_WIDTH = 4;
    localparam int BCD_DIGIT_WIDTH     = 4;
    localparam int BCD_RADIX           = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Index register width; a single-block word still needs one bit.
    function automatic int idx_width(input int num_blocks);
        return (num_blocks > 1) ? $clog2(num_blocks) : 1;
    endfunction

endpackage

// File: rtl/alu_sub_slice.sv
// One BLOCK_WIDTH-wide subtract step with borrow in/out.
// With ALU_SUB_BCD_EN defined the slice is a BCD digit (BLOCK_WIDTH must then be 4).
module alu_sub_slice
    import alu_sub_serial_pkg::*;
#(
    parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
) (
    input  logic [BLOCK_WIDTH-1:0] a_i,
    input  logic [BLOCK_WIDTH-1:0] b_i,
    input  logic                   bin_i,
    output logic [BLOCK_WIDTH-1:0] diff_o,
    output logic                   bout_o
);

    logic [BLOCK_WIDTH:0] raw_d;

    always_comb begin
        raw_d = {1'b0, a_i} - {1'b0, b_i} - {{BLOCK_WIDTH{1'b0}}, bin_i};
`ifdef ALU_SUB_BCD_EN
        // A negative raw digit sets bit BLOCK_WIDTH; fold it back into 0..9 by adding the radix.
        if (raw_d[BLOCK_WIDTH]) begin
            diff_o = raw_d[BLOCK_WIDTH-1:0] + BLOCK_WIDTH'(BCD_RADIX);
            bout_o = 1'b1;
        end else begin
            diff_o = raw_d[BLOCK_WIDTH-1:0];
            bout_o = 1'b0;
        end
`else
        diff_o = raw_d[BLOCK_WIDTH-1:0];
        bout_o = raw_d[BLOCK_WIDTH];
`endif
    end

endmodule

// File: rtl/alu_sub_serial.sv
// Serial subtractor: a - b computed BLOCK_WIDTH bits per cycle, LSB slice first.
// Define ALU_SUB_BCD_EN for packed-BCD subtraction (BLOCK_WIDTH = 4).
//
//   state   | meaning
//   ST_IDLE | waiting for start
//   ST_RUN  | one slice per cycle, borrow carried in bin_q
//   ST_DONE | result loaded, done pulse; start accepted here too
module alu_sub_serial
    import alu_sub_serial_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] diff,
    output logic                  borrow
);

    localparam int NUM_BLOCKS = WORD_WIDTH / BLOCK_WIDTH;
    localparam int IDX_W      = idx_width(NUM_BLOCKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    alu_state_e              state_q;
    logic [WORD_WIDTH-1:0]   a_q;
    logic [WORD_WIDTH-1:0]   b_q;
    logic [WORD_WIDTH-1:0]   acc_q;
    logic [WORD_WIDTH-1:0]   acc_d;
    logic [WORD_WIDTH-1:0]   diff_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    bin_q;
    logic                    borrow_q;
    logic                    busy_q;
    logic                    done_q;
    logic [BLOCK_WIDTH-1:0]  slice_diff_d;
    logic                    slice_bout_d;

    alu_sub_slice #(
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_slice (
        .a_i    (a_q[BLOCK_WIDTH-1:0]),
        .b_i    (b_q[BLOCK_WIDTH-1:0]),
        .bin_i  (bin_q),
        .diff_o (slice_diff_d),
        .bout_o (slice_bout_d)
    );

    // Results enter at the top of acc_q so slice 0 lands at the LSB after the final shift.
    generate
        if (NUM_BLOCKS == 1) begin : g_single
            assign acc_d = slice_diff_d;
        end else begin : g_multi
            assign acc_d = {slice_diff_d, acc_q[WORD_WIDTH-1:BLOCK_WIDTH]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        bin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_q >> BLOCK_WIDTH;
                    b_q   <= b_q >> BLOCK_WIDTH;
                    acc_q <= acc_d;
                    bin_q <= slice_bout_d;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        diff_q   <= acc_d;
                        borrow_q <= slice_bout_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_alu_sub_serial.sv
// Bench for alu_sub_serial: directed cases with literal results plus random traffic
// against an arithmetic model. Define ALU_SUB_BCD_EN to exercise the BCD build.
module tb_alu_sub_serial;

    localparam int W  = 32;
    localparam int BW = 4;
    localparam int N  = W / BW;
    localparam int ND = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int n_vec  = 0;
    int n_miss = 0;

    alu_sub_serial #(.WORD_WIDTH(W), .BLOCK_WIDTH(BW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

`ifdef ALU_SUB_BCD_EN
    function automatic longint bcd_to_int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = ND - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input longint v);
        logic [W-1:0] r = '0;
        longint t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        logic [W-1:0] r = '0;
        int sel = $urandom_range(0, 7);
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if (sel == 0) r = '0;
        return r;
    endfunction

    task automatic ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] d, output logic bo);
        longint dx = bcd_to_int(x);
        longint dy = bcd_to_int(y);
        longint m  = 1;
        for (int i = 0; i < ND; i++) m = m * 10;
        bo = (dx < dy);
        d  = int_to_bcd(bo ? dx - dy + m : dx - dy);
    endtask
`else
    function automatic logic [W-1:0] rnd_opnd();
        int sel = $urandom_range(0, 7);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        if (sel == 2) return W'($urandom_range(0, 3));
        return W'($urandom);
    endfunction

    task automatic ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] d, output logic bo);
        d  = x - y;
        bo = (x < y);
    endtask
`endif

    // Cycle-level expectation: an accepted start gives N busy cycles, then one done cycle.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_borrow = 1'b0;
    logic [W-1:0] p_diff;
    logic         p_borrow;
    int           m_left = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_diff   = '0;
            m_borrow = 1'b0;
            m_left   = 0;
        end
        check("busy",   64'(busy),   64'(m_busy));
        check("done",   64'(done),   64'(m_done));
        check("diff",   64'(diff),   64'(m_diff));
        check("borrow", 64'(borrow), 64'(m_borrow));
        if (!rst) begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_diff   = p_diff;
                    m_borrow = p_borrow;
                end
            end else if (start) begin
                ref_sub(a, b, p_diff, p_borrow);
                m_left = N;
                m_busy = 1'b1;
            end
        end
    end

    // Leaves the caller at #1 after the edge that opens the done cycle.
    task automatic op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic [W-1:0] ed, input logic eb, input bit b2b, input bit hold);
        int c;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        start = 1'b1; a = ta; b = tb;
        @(posedge clk); #1;
        check({nm, "_busy1"}, 64'(busy), 64'(1));
        c = 1;
        while (done !== 1'b1 && c < 20) begin
            if (hold) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        check({nm, "_lat"},    64'(c),      64'(N + 1));
        check({nm, "_diff"},   64'(diff),   64'(ed));
        check({nm, "_borrow"}, 64'(borrow), 64'(eb));
        check({nm, "_nbusy"},  64'(busy),   64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   64'(busy),   64'(0));
        check("rst_done",   64'(done),   64'(0));
        check("rst_diff",   64'(diff),   64'(0));
        check("rst_borrow", 64'(borrow), 64'(0));
        rst = 1'b0;

`ifdef ALU_SUB_BCD_EN
        op("bcd_42_17", 32'h42, 32'h17, 32'h25, 1'b0, 1'b0, 1'b0);
        op("bcd_0_1",   32'h0,  32'h1,  32'h99999999, 1'b1, 1'b0, 1'b0);
        op("hold",      32'h100, 32'h1, 32'h99, 1'b0, 1'b0, 1'b1);
`else
        op("5_3",  32'h5, 32'h3, 32'h2, 1'b0, 1'b0, 1'b0);
        op("0_1",  32'h0, 32'h1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        op("hold", 32'h100, 32'h1, 32'hFF, 1'b0, 1'b0, 1'b1);
`endif
        op("b2b", 32'h10, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);

        @(posedge clk); #1;
        start = 1'b1; a = 32'h99; b = 32'h11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_diff", 64'(diff), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            @(posedge clk); #1;
            check("abort_nodone", 64'(done), 64'(0));
        end
        op("7_2", 32'h7, 32'h2, 32'h5, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 2) == 0);
            a     = rnd_opnd();
            b     = rnd_opnd();
            if ($urandom_range(0, 9) == 0) b = a;
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
